// File: rtl/ureg_ctrl_pkg.sv
// Shared types and constants for the universal shift register sequencer.
package ureg_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_TX = 2'b00,
    OP_RX = 2'b01,
    OP_WR = 2'b10,
    OP_RD = 2'b11
  } op_e;

  localparam logic [1:0] MODE_SISO = 2'b00;
  localparam logic [1:0] MODE_SIPO = 2'b01;
  localparam logic [1:0] MODE_PISO = 2'b10;
  localparam logic [1:0] MODE_PIPO = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_SCRUB = 3'd5
  } state_e;

endpackage

// File: rtl/ureg_bit_counter.sv
// Loadable serial-bit counter; tc_c flags the increment that reaches WIDTH.
module ureg_bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [$clog2(WIDTH+1)-1:0]   load_val,
  input  logic                         inc,
  output logic                         tc_c
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc_c = inc && (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/ureg_seq_ctrl.sv
// Byte-command sequencer for the Hamming-protected universal shift register,
// with idle-time scrubbing of single-bit errors.
module ureg_seq_ctrl
  import ureg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SCRUB_EN = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             tx_bit,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             rx_bit,
  input  logic             rx_valid,
  output logic             reg_enable,
  output logic [1:0]       reg_mode,
  output logic             reg_load,
  output logic             reg_serial_in,
  output logic [WIDTH-1:0] reg_parallel_in,
  input  logic             reg_serial_out,
  input  logic [WIDTH-1:0] reg_parallel_out,
  input  logic             ecc_single_err,
  input  logic             ecc_double_err,
  output logic             busy,
  output logic [CNT_W-1:0] scrub_cnt
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e state_q, state_d;
  op_e    op_q;
  logic   accept;
  logic   scrub_pend;
  logic   cnt_inc;
  logic   cnt_tc;
  logic   in_op;

  ureg_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CW'(0)),
    .inc      (cnt_inc),
    .tc_c     (cnt_tc)
  );

  assign scrub_pend = SCRUB_EN && ecc_single_err;
  assign in_op      = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_CAPT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle register drive; every output defaults to idle.
  always_comb begin
    state_d         = state_q;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    tx_valid        = 1'b0;
    tx_bit          = 1'b0;
    reg_enable      = 1'b0;
    reg_mode        = MODE_SISO;
    reg_load        = 1'b0;
    reg_serial_in   = 1'b0;
    reg_parallel_in = '0;
    accept          = 1'b0;
    cnt_inc         = 1'b0;
    busy            = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = !scrub_pend;
        if (scrub_pend) begin
          state_d = ST_SCRUB;
        end else if (cmd_valid) begin
          accept = 1'b1;
          unique case (op_e'(cmd_op))
            OP_TX, OP_WR: state_d = ST_LOAD;
            OP_RX:        state_d = ST_SHIFT;
            OP_RD:        state_d = ST_CAPT;
          endcase
        end
      end
      ST_LOAD: begin
        reg_enable      = 1'b1;
        reg_load        = 1'b1;
        reg_parallel_in = rsp_data;
        reg_mode        = (op_q == OP_TX) ? MODE_PISO : MODE_PIPO;
        state_d         = (op_q == OP_TX) ? ST_SHIFT : ST_RESP;
      end
      ST_SHIFT: begin
        if (op_q == OP_TX) begin
          reg_mode   = MODE_PISO;
          tx_valid   = 1'b1;
          tx_bit     = reg_serial_out;
          reg_enable = tx_ready;
          cnt_inc    = tx_ready;
          if (cnt_tc) state_d = ST_RESP;
        end else begin
          reg_mode      = MODE_SIPO;
          reg_serial_in = rx_bit;
          reg_enable    = rx_valid;
          cnt_inc       = rx_valid;
          if (cnt_tc) state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      ST_SCRUB: begin
        reg_mode        = MODE_PIPO;
        reg_load        = 1'b1;
        reg_enable      = 1'b1;
        reg_parallel_in = reg_parallel_out;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rsp_data doubles as the latched command data until CAPT replaces it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_TX;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= op_e'(cmd_op);
        rsp_data <= cmd_data;
        rsp_err  <= 1'b0;
      end else begin
        if (state_q == ST_CAPT) rsp_data <= reg_parallel_out;
        if (in_op && ecc_double_err) rsp_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scrub_cnt <= '0;
    end else if ((state_q == ST_SCRUB) && (scrub_cnt != {CNT_W{1'b1}})) begin
      scrub_cnt <= scrub_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ureg_seq_ctrl.sv
// Scoreboard bench for ureg_seq_ctrl with a behavioural shift register and
// an injectable error mask standing in for the Hamming decoder.
module tb_ureg_seq_ctrl;
  import ureg_ctrl_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             tx_bit;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic             rx_bit = 1'b0;
  logic             rx_valid = 1'b0;
  logic             reg_enable;
  logic [1:0]       reg_mode;
  logic             reg_load;
  logic             reg_serial_in;
  logic [WIDTH-1:0] reg_parallel_in;
  logic             reg_serial_out;
  logic [WIDTH-1:0] reg_parallel_out;
  logic             ecc_single_err;
  logic             ecc_double_err;
  logic             busy;
  logic [CNT_W-1:0] scrub_cnt;

  logic [WIDTH-1:0] stored = '0;
  logic [WIDTH-1:0] flip = '0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               lat;
    int               acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  ureg_seq_ctrl #(.WIDTH(WIDTH), .SCRUB_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_data         (cmd_data),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .tx_bit           (tx_bit),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_bit           (rx_bit),
    .rx_valid         (rx_valid),
    .reg_enable       (reg_enable),
    .reg_mode         (reg_mode),
    .reg_load         (reg_load),
    .reg_serial_in    (reg_serial_in),
    .reg_parallel_in  (reg_parallel_in),
    .reg_serial_out   (reg_serial_out),
    .reg_parallel_out (reg_parallel_out),
    .ecc_single_err   (ecc_single_err),
    .ecc_double_err   (ecc_double_err),
    .busy             (busy),
    .scrub_cnt        (scrub_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register model: parallel load or shift-left with serial_in at the LSB.
  always @(posedge clk) begin
    if (reg_enable) begin
      if (reg_load) stored <= reg_parallel_in;
      else          stored <= {stored[WIDTH-2:0], reg_serial_in};
    end
  end

  assign reg_parallel_out = stored;
  assign reg_serial_out   = stored[WIDTH-1];
  assign ecc_single_err   = ($countones(flip) == 1);
  assign ecc_double_err   = ($countones(flip) == 2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pop and compare on every presented response.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        mon_item = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(mon_item.data));
        chk("rsp_err", 32'(rsp_err), 32'(mon_item.err));
        chk("rsp_latency", 32'(cyc - mon_item.acc), 32'(mon_item.lat));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] d, input bit push,
                      input logic [7:0] ed, input logic ee, input int el);
    exp_t it;
    int   guard = 0;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    it.data = ed;
    it.err  = ee;
    it.lat  = el;
    it.acc  = cyc;
    if (push) sb.push_back(it);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) chk("rsp_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic collect_tx(input int nbits, output logic [7:0] got,
                            output int first, output int last);
    int n = 0;
    int guard = 0;
    got   = '0;
    first = 0;
    last  = 0;
    while (n < nbits && guard < 40) begin
      @(negedge clk);
      guard++;
      if (tx_valid) begin
        got[7-n] = tx_bit;
        if (n == 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    if (n < nbits) chk("tx_timeout", 32'(n), 32'(nbits));
  endtask

  task automatic drive_rx(input logic [7:0] bits, input int stall_at, input int stall_n,
                          input int flip_at, input logic [7:0] fmask);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          rx_valid = 1'b0;
          @(negedge clk);
          chk("stall_reg_enable", 32'(reg_enable), 32'd0);
          @(posedge clk);
          #1;
        end
      end
      if (i == flip_at) flip = fmask;
      rx_valid = 1'b1;
      rx_bit   = bits[7-i];
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
  endtask

  initial begin
    logic [7:0] got;
    int first, last;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_reg_enable", 32'(reg_enable), 32'd0);
    chk("rst_scrub_cnt", 32'(scrub_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    send(2'(OP_WR), 8'hA5, 1'b1, 8'hA5, 1'b0, 2);
    wait_drain();
    send(2'(OP_RD), 8'h00, 1'b1, 8'hA5, 1'b0, 2);
    wait_drain();

    send(2'(OP_TX), 8'h74, 1'b1, 8'h74, 1'b0, 10);
    collect_tx(8, got, first, last);
    chk("tx_bits", 32'(got), 32'h74);
    chk("tx_span", 32'(last - first), 32'd7);
    wait_drain();

    send(2'(OP_RX), 8'h00, 1'b1, 8'h8B, 1'b0, 13);
    drive_rx(8'h8B, 4, 3, -1, 8'h00);
    wait_drain();

    // Single-bit error while idle triggers one scrub write-back.
    flip = 8'h04;
    @(negedge clk);
    chk("scrub_pend_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    flip = 8'h00;
    @(negedge clk);
    chk("scrub_busy", 32'(busy), 32'd1);
    chk("scrub_reg_load", 32'(reg_load), 32'd1);
    chk("scrub_reg_enable", 32'(reg_enable), 32'd1);
    chk("scrub_reg_mode", 32'(reg_mode), 32'd3);
    chk("scrub_parallel_in", 32'(reg_parallel_in), 32'h8B);
    chk("scrub_cnt_before", 32'(scrub_cnt), 32'd0);
    @(negedge clk);
    chk("scrub_cnt_after", 32'(scrub_cnt), 32'd1);
    chk("scrub_done_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    send(2'(OP_RD), 8'h00, 1'b1, 8'h8B, 1'b0, 2);
    wait_drain();

    send(2'(OP_RX), 8'h00, 1'b1, 8'hCC, 1'b1, 10);
    drive_rx(8'hCC, -1, 0, 3, 8'h81);
    wait_drain();
    flip = 8'h00;
    send(2'(OP_WR), 8'h3C, 1'b1, 8'h3C, 1'b0, 2);
    wait_drain();
    send(2'(OP_RD), 8'h00, 1'b1, 8'h3C, 1'b0, 2);
    wait_drain();

    // Abort a transmit half way through with an asynchronous reset.
    send(2'(OP_TX), 8'h5A, 1'b0, 8'h00, 1'b0, 0);
    collect_tx(4, got, first, last);
    chk("abort_tx_bits", 32'(got[7:4]), 32'h5);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_reg_enable", 32'(reg_enable), 32'd0);
    chk("abort_reg_mode", 32'(reg_mode), 32'd0);
    chk("abort_rsp_data", 32'(rsp_data), 32'd0);
    chk("abort_scrub_cnt", 32'(scrub_cnt), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(2'(OP_WR), 8'h96, 1'b1, 8'h96, 1'b0, 2);
    wait_drain();
    send(2'(OP_RD), 8'h00, 1'b1, 8'h96, 1'b0, 2);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ureg_seq_ctrl.md
Name: ureg_seq_ctrl

Overview:
- Sequencer for the 8-bit Hamming-protected universal shift register (modes SISO/SIPO/PISO/PIPO).
- Accepts byte-level commands over a valid/ready interface: transmit serially, receive serially, parallel write, parallel read.
- Generates the register's enable/mode/load/serial_in/parallel_in cycle by cycle and returns a response with ECC status.
- Scrubs the register when idle by writing back the corrected word after a single-bit ECC error.

Parameters:
- WIDTH, 8, register width and bits per serial transfer.
- SCRUB_EN, 1, enables automatic write-back on single-bit error.
- CNT_W, 8, width of the saturating scrub counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  00=TX (PISO), 01=RX (SIPO), 10=WR (PIPO load), 11=RD
- cmd_data  in  WIDTH  data for TX/WR
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  WIDTH  TX/WR: echoed data; RX/RD: register word
- rsp_err  out  1  uncorrectable (double) error seen during the operation
- tx_bit  out  1  serial output bit
- tx_valid  out  1  tx_bit valid
- tx_ready  in  1  sink accepts tx_bit
- rx_bit  in  1  serial input bit
- rx_valid  in  1  rx_bit valid
- reg_enable  out  1  to register enable
- reg_mode  out  2  to register mode
- reg_load  out  1  to register load
- reg_serial_in  out  1  to register serial_in
- reg_parallel_in  out  WIDTH  to register parallel_in
- reg_serial_out  in  1  from register
- reg_parallel_out  in  WIDTH  from register, corrected word
- ecc_single_err  in  1  decoder: corrected single-bit error
- ecc_double_err  in  1  decoder: uncorrectable error
- busy  out  1  state != IDLE
- scrub_cnt  out  CNT_W  number of scrubs performed, saturating

Behaviour:
- Reset (rst=0, async): state IDLE; bit counter 0; all outputs 0 except cmd_ready=1. scrub_cnt=0. An operation in progress is abandoned with no response.
- States: IDLE, LOAD, SHIFT, CAPT, RESP, SCRUB.
- IDLE: cmd_ready=1 unless a scrub is pending. If ecc_single_err && SCRUB_EN, go to SCRUB; a scrub takes priority over a simultaneous cmd_valid. On accept, latch op and data.
  - TX or WR -> LOAD.
  - RX -> SHIFT.
  - RD -> CAPT.
- LOAD (1 cycle): reg_enable=1, reg_load=1, reg_parallel_in=latched data, reg_mode = TX ? 10 : 11.
  - Next: TX -> SHIFT; WR -> RESP.
- SHIFT, TX: reg_mode=10, tx_valid=1, tx_bit=reg_serial_out, MSB first.
  - reg_enable = tx_ready; the counter increments on tx_ready.
  - After WIDTH accepted bits -> RESP.
- SHIFT, RX: reg_mode=01, reg_serial_in=rx_bit.
  - reg_enable = rx_valid; the counter increments on rx_valid.
  - After WIDTH bits -> CAPT.
- Stall in SHIFT: no register activity and no counter change while the handshake is low.
- CAPT (1 cycle, lets the decoder settle): register rsp_data=reg_parallel_out -> RESP.
- rsp_err: sticky per operation. Set if ecc_double_err is high in any cycle from LOAD/SHIFT/CAPT through entry to RESP. Cleared on the next command accept.
- RESP: rsp_valid=1, with rsp_data and rsp_err stable. On rsp_ready -> IDLE; the next command can be accepted in the following cycle.
- Latencies, accept to rsp_valid, with no stalls:
  - TX: WIDTH+2 cycles.
  - RX: WIDTH+2 cycles.
  - WR: 2 cycles.
  - RD: 2 cycles.
- SCRUB (1 cycle): reg_mode=11, reg_load=1, reg_enable=1, reg_parallel_in=reg_parallel_out. scrub_cnt increments, saturating at all-ones. Then IDLE.
- A scrub is never inserted mid-operation. A single-bit error during an operation is corrected by the decoder on read, and is scrubbed on return to IDLE if it persists.
- reg_* outputs are 0 in IDLE and RESP, so the register holds.

Decomposition:
- ureg_ctrl_pkg:
  - op enum: OP_TX, OP_RX, OP_WR, OP_RD.
  - mode constants: MODE_SISO=00, MODE_SIPO=01, MODE_PISO=10, MODE_PIPO=11.
  - state enum.
- One sub-module: ureg_bit_counter, a loadable counter with increment enable and terminal-count flag at WIDTH.

Test Plan:
- WR 8'hA5, then RD, with rsp_ready=1 -> RD response 8'hA5, rsp_err=0; each response 2 cycles after accept.
- TX 8'h74, tx_ready=1 -> tx_bit sequence 0,1,1,1,0,1,0,0 over 8 consecutive cycles; rsp_data=8'h74 at cycle 10.
- RX with bits 1,0,0,0,1,0,1,1 and rx_valid deasserted for 3 cycles mid-stream -> rsp_data=8'h8B; reg_enable low during the stall; latency 13 cycles.
- Force one register bit flipped while IDLE (single error) -> SCRUB in the next cycle with reg_load=1; scrub_cnt 0->1; a subsequent RD returns the original word.
- Force two bits flipped during an RX -> rsp_err=1; the next command's response has rsp_err=0.
- Drop rst mid-TX at bit 4 -> all outputs 0 and cmd_ready=1 asynchronously; no rsp_valid; a new WR after release completes normally.
